// File: rtl/riscv_pkg.sv
// Shared decode types: immediate-format select encodings and default widths.
// Buffer entry layout is {imm, tag, err}; the struct is declared where XLEN/TAG_W are bound.
package riscv_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [3:0] {
    IMM_I  = 4'd0,
    IMM_S  = 4'd1,
    IMM_B  = 4'd2,
    IMM_U  = 4'd3,
    IMM_J  = 4'd4,
    IMM_Z  = 4'd5,
    IMM_SH = 4'd6,
    IMM_CI = 4'd7,
    IMM_CJ = 4'd8,
    IMM_CB = 4'd9
  } imm_sel_e;

  // Field widths of one buffered entry, for consumers that size storage externally.
  localparam int ENTRY_ERR_W = 1;

endpackage

// File: rtl/imm_stage_if.sv
// Handshake bundle for imm_stage: instruction-in side and immediate-out side.
// slave is the stage's view, master is the producer/consumer view.
interface imm_stage_if
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [3:0]       imm_sel_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [TAG_W-1:0] tag_o;
  logic             err_o;

  modport slave (
    input  in_valid_i, instr_i, imm_sel_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, tag_o, err_o
  );

  modport master (
    output in_valid_i, instr_i, imm_sel_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, tag_o, err_o
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction (0 cycles, no backpressure); RVC formats only when
// RVC_IMM_EN is defined, otherwise selects 7-9 are reported as illegal.
module imm_extract
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Every format fits in 32 bits, so assemble it sign-extended to 32 and widen once.
  logic [31:0] field;
  logic        unused_opc;

  assign unused_opc = ^instr[6:0];

  always_comb begin
    field = '0;
    err   = 1'b0;
    case (sel)
      IMM_I:  field = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  field = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  field = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:  field = {instr[31:12], 12'b0};
      IMM_J:  field = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:  field = {27'b0, instr[19:15]};
      IMM_SH: field = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
`ifdef RVC_IMM_EN
      IMM_CI: field = {{26{instr[12]}}, instr[12], instr[6:2]};
      IMM_CJ: field = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                       instr[2], instr[11], instr[5:3], 1'b0};
      IMM_CB: field = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                       instr[4:3], 1'b0};
`endif
      default: err = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(field));

endmodule

// File: rtl/imm_stage.sv
// Immediate-generation stage: 1-cycle latency into a DEPTH-entry FIFO of {imm, tag, err}.
// in_ready_o drops only when full (state-only); optional RVC formats via RVC_IMM_EN.
module imm_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 2,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic         clk_i,
  input logic         rst_i,
  input logic         flush_i,
  imm_stage_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } imm_entry_t;

  imm_entry_t       mem [DEPTH];
  imm_entry_t       wr_entry;
  imm_entry_t       head;
  logic [XLEN-1:0]  ext_imm;
  logic             ext_err;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (bus.instr_i),
    .sel   (bus.imm_sel_i),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  assign wr_entry = '{imm: ext_imm, tag: bus.tag_i, err: ext_err};

  assign bus.in_ready_o  = (count != CNT_W'(DEPTH));
  assign bus.out_valid_o = (count != '0);
  assign push = bus.in_valid_i && bus.in_ready_o;
  assign pop  = bus.out_valid_o && bus.out_ready_i;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= wr_entry;
  end

  assign head = bus.out_valid_o ? mem[rd_ptr] : '0;
  assign bus.imm_o = head.imm;
  assign bus.tag_o = head.tag;
  assign bus.err_o = head.err;

endmodule

// File: doc/imm_stage.md
# imm_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It accepts one instruction word per cycle with an immediate-format select and a caller tag over a valid/ready handshake. It produces the sign- or zero-extended XLEN immediate one cycle later through a DEPTH-entry output buffer. Beyond the base RV32I formats it adds CSR-zimm, shift-amount and, optionally, RVC immediates, plus an illegal-select error flag and a pipeline flush.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 and 64.
- DEPTH, 2, output buffer entries; minimum 1.
- TAG_W, 4, width of the pass-through tag.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  synchronous buffer clear.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  stage can accept a word.
- instr_i  in  32  instruction word; RVC forms occupy bits [15:0].
- imm_sel_i  in  4  format select, riscv_pkg::imm_sel_e.
- tag_i  in  TAG_W  caller tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts the head entry.
- imm_o  out  XLEN  immediate of the head entry.
- tag_o  out  TAG_W  tag of the head entry.
- err_o  out  1  head entry had an illegal select.

## Operation
Format encodings and results:
- IMM_I=0: sext(instr[31:20]).
- IMM_S=1: sext({instr[31:25], instr[11:7]}).
- IMM_B=2: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- IMM_U=3: sext({instr[31:12], 12'b0}).
- IMM_J=4: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- IMM_Z=5: zext(instr[19:15]).
- IMM_SH=6: zext(instr[25:20]) when XLEN=64; zext(instr[24:20]) when XLEN=32.
- IMM_CI=7, IMM_CJ=8, IMM_CB=9: see Configuration.

All sign extensions replicate the top bit of the assembled field to XLEN.

Illegal select (any other encoding, or an RVC select with the macro off):
- Result imm = 0 with err = 1.
- The entry is still buffered and delivered in order.

Buffer behaviour:
- Circular FIFO holding {imm, tag, err}, with a count register, write pointer and read pointer.
- Push when in_valid_i && in_ready_o.
- Pop when out_valid_o && out_ready_i.
- in_ready_o = (count != DEPTH). It depends only on state, not on out_ready_i.
- out_valid_o = (count != 0).
- When empty, imm_o, tag_o and err_o are driven to 0.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any count below DEPTH.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- flush_i: count and both pointers return to 0 on the next edge. A push or pop in the same cycle is discarded.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, imm_o=0, tag_o=0, err_o=0. Count and pointers are 0. Storage is not reset.
- Latency: a word accepted at edge N appears at the head (if the buffer was empty) with out_valid_o=1 after edge N.
- Throughput: one word per cycle while out_ready_i=1.
- Full: in_ready_o=0 until a pop edge. A pop at full does not allow a push in that same cycle.
- Reset asserted mid-operation clears all state immediately and asynchronously. In-flight entries are lost.

## Configuration
- RVC_IMM_EN defined: RVC selects are legal, computed on instr[15:0] ("inst").
  - IMM_CI: sext({inst[12], inst[6:2]}).
  - IMM_CJ: offset[11|4|9:8|10|6|7|3:1|5] = inst[12|11|10:9|8|7|6|5:3|2], bit0 = 0, sign-extended.
  - IMM_CB: offset[8|4:3] = inst[12|11:10], offset[7:6|2:1|5] = inst[6:5|4:3|2], bit0 = 0, sign-extended.
- RVC_IMM_EN undefined: codes 7–9 are illegal (imm=0, err=1). The RVC extraction logic is absent.

## Structure
- riscv_pkg holds:
  - the imm_sel_e enum (4-bit, encodings above);
  - XLEN default constant;
  - an imm_entry_t struct template, or the field widths for it.
- Sub-module imm_extract: purely combinational. Inputs instr and sel; outputs imm and err; parameter XLEN.
- imm_stage instantiates imm_extract and owns the handshake and FIFO.

## Test plan
All checks use XLEN=64 and DEPTH=2 unless stated.
- Reset: assert rst_i mid-stream with 2 entries buffered. Required: out_valid_o=0, in_ready_o=1 and imm_o=0 immediately; after release the next push delivers normally.
- Base formats, each pushed with out_ready_i=1, one cycle later:
  - instr 0xFFF00093 IMM_I → imm_o=0xFFFFFFFFFFFFFFFF.
  - 0x80000037 IMM_U → 0xFFFFFFFF80000000.
  - 0x8000006F IMM_J → 0xFFFFFFFFFFF00000.
  - 0x02505013 IMM_SH → 0x25.
- Backpressure: out_ready_i=0, three back-to-back pushes. Required: in_ready_o=0 after the second; the third is held until a pop. Tags are delivered in order 1, 2, 3.
- Simultaneous push/pop at count=1 for 10 cycles. Required: count stays 1, no drops or duplicates, pointers wrap.
- Flush with 2 entries plus a same-cycle push. Required: out_valid_o=0 next cycle and nothing delivered.
- Illegal/RVC select: instr 0x0000BFFD with IMM_CJ.
  - With RVC_IMM_EN: imm_o=0xFFFFFFFFFFFFFFFE, err_o=0.
  - Without RVC_IMM_EN: imm_o=0, err_o=1.
  - Select 15 in either build: err_o=1.
